// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage between the instruction decoder and execute.
//
// Holds the register file and a per-register busy scoreboard. A decoded
// instruction is issued one cycle after acceptance with its operand data
// resolved. An instruction that hits a busy register waits in a one-entry hold
// register until the producer writes back.
//
// Ports:
//   clock_i, reset_i          clock and synchronous active-high reset
//   flushBack_i               pipeline flush (drops held instruction, clears busy)
//   enable_i .. sRead_i       decoded instruction from the decoder
//   wbEnable_i/wbReg_i/Data_i writeback from execute
//   stall_o                   an instruction is held here; upstream must hold off
//   enable_o .. secData_o     issued instruction to execute

module operand_fetch #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  flushBack_i,
    input  logic                  enable_i,
    input  logic [6:0]            opcode_i,
    input  logic [1:0]            functionType_i,
    input  logic [4:0]            primOperand_i,
    input  logic [15:0]           secOperand_i,
    input  logic                  pRead_i,
    input  logic                  pWrite_i,
    input  logic                  sRead_i,
    input  logic                  wbEnable_i,
    input  logic [4:0]            wbReg_i,
    input  logic [DATA_WIDTH-1:0] wbData_i,
    output logic                  stall_o,
    output logic                  enable_o,
    output logic [6:0]            opcode_o,
    output logic [1:0]            functionType_o,
    output logic [4:0]            primOperand_o,
    output logic                  pWrite_o,
    output logic [DATA_WIDTH-1:0] primData_o,
    output logic [DATA_WIDTH-1:0] secData_o
);

    // Register file and scoreboard
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    // Hold register
    logic        hold_valid_q, hold_valid_d;
    logic [6:0]  hold_opcode_q, hold_opcode_d;
    logic [1:0]  hold_ftype_q, hold_ftype_d;
    logic [4:0]  hold_prim_q, hold_prim_d;
    logic [15:0] hold_sec_q, hold_sec_d;
    logic        hold_pread_q, hold_pread_d;
    logic        hold_pwrite_q, hold_pwrite_d;
    logic        hold_sread_q, hold_sread_d;

    // Issue outputs
    logic                  enable_q, enable_d;
    logic [6:0]            opcode_q, opcode_d;
    logic [1:0]            ftype_q, ftype_d;
    logic [4:0]            prim_q, prim_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] prim_data_q, prim_data_d;
    logic [DATA_WIDTH-1:0] sec_data_q, sec_data_d;

    // Candidate instruction
    logic                  cand_valid;
    logic [6:0]            cand_opcode;
    logic [1:0]            cand_ftype;
    logic [4:0]            cand_prim;
    logic [15:0]           cand_sec;
    logic                  cand_pread, cand_pwrite, cand_sread;
    logic [NUM_REGS-1:0]   wb_mask, busy_eff;
    logic                  hazard, issue;
    logic [DATA_WIDTH-1:0] prim_rd, sec_rd;

    always_comb begin
        // The held instruction has priority; enable_i is ignored while holding.
        cand_valid  = hold_valid_q | enable_i;
        cand_opcode = hold_valid_q ? hold_opcode_q : opcode_i;
        cand_ftype  = hold_valid_q ? hold_ftype_q  : functionType_i;
        cand_prim   = hold_valid_q ? hold_prim_q   : primOperand_i;
        cand_sec    = hold_valid_q ? hold_sec_q    : secOperand_i;
        cand_pread  = hold_valid_q ? hold_pread_q  : pRead_i;
        cand_pwrite = hold_valid_q ? hold_pwrite_q : pWrite_i;
        cand_sread  = hold_valid_q ? hold_sread_q  : sRead_i;

        // A writeback landing this cycle resolves the dependency immediately.
        wb_mask = '0;
        if (wbEnable_i) wb_mask[wbReg_i] = 1'b1;
        busy_eff = busy_q & ~wb_mask;

        hazard = (cand_pread  & busy_eff[cand_prim])
               | (cand_sread  & busy_eff[cand_sec[4:0]])
               | (cand_pwrite & busy_eff[cand_prim]);
        issue  = cand_valid & ~hazard & ~flushBack_i;

        // Operand reads with writeback bypass
        prim_rd = (wbEnable_i && wbReg_i == cand_prim) ? wbData_i : regs_q[cand_prim];
        sec_rd  = (wbEnable_i && wbReg_i == cand_sec[4:0]) ? wbData_i
                                                           : regs_q[cand_sec[4:0]];

        // Register file: writeback always lands, even during a flush.
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
        if (wbEnable_i) regs_d[wbReg_i] = wbData_i;

        // Scoreboard: clear on writeback, then set on issue so a new producer wins.
        busy_d = busy_q & ~wb_mask;
        if (issue && cand_pwrite) busy_d[cand_prim] = 1'b1;
        if (flushBack_i) busy_d = '0;

        // Hold register
        hold_valid_d  = 1'b0;
        hold_opcode_d = hold_opcode_q;
        hold_ftype_d  = hold_ftype_q;
        hold_prim_d   = hold_prim_q;
        hold_sec_d    = hold_sec_q;
        hold_pread_d  = hold_pread_q;
        hold_pwrite_d = hold_pwrite_q;
        hold_sread_d  = hold_sread_q;
        if (!flushBack_i && cand_valid && hazard) begin
            hold_valid_d = 1'b1;
            if (!hold_valid_q) begin
                hold_opcode_d = opcode_i;
                hold_ftype_d  = functionType_i;
                hold_prim_d   = primOperand_i;
                hold_sec_d    = secOperand_i;
                hold_pread_d  = pRead_i;
                hold_pwrite_d = pWrite_i;
                hold_sread_d  = sRead_i;
            end
        end

        // Issue outputs keep their last values when nothing issues.
        enable_d    = issue;
        opcode_d    = opcode_q;
        ftype_d     = ftype_q;
        prim_d      = prim_q;
        pwrite_d    = pwrite_q;
        prim_data_d = prim_data_q;
        sec_data_d  = sec_data_q;
        if (issue) begin
            opcode_d    = cand_opcode;
            ftype_d     = cand_ftype;
            prim_d      = cand_prim;
            pwrite_d    = cand_pwrite;
            prim_data_d = cand_pread ? prim_rd : '0;
            sec_data_d  = cand_sread ? sec_rd : DATA_WIDTH'(cand_sec);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            busy_q        <= '0;
            hold_valid_q  <= 1'b0;
            hold_opcode_q <= '0;
            hold_ftype_q  <= '0;
            hold_prim_q   <= '0;
            hold_sec_q    <= '0;
            hold_pread_q  <= 1'b0;
            hold_pwrite_q <= 1'b0;
            hold_sread_q  <= 1'b0;
            enable_q      <= 1'b0;
            opcode_q      <= '0;
            ftype_q       <= '0;
            prim_q        <= '0;
            pwrite_q      <= 1'b0;
            prim_data_q   <= '0;
            sec_data_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
            busy_q        <= busy_d;
            hold_valid_q  <= hold_valid_d;
            hold_opcode_q <= hold_opcode_d;
            hold_ftype_q  <= hold_ftype_d;
            hold_prim_q   <= hold_prim_d;
            hold_sec_q    <= hold_sec_d;
            hold_pread_q  <= hold_pread_d;
            hold_pwrite_q <= hold_pwrite_d;
            hold_sread_q  <= hold_sread_d;
            enable_q      <= enable_d;
            opcode_q      <= opcode_d;
            ftype_q       <= ftype_d;
            prim_q        <= prim_d;
            pwrite_q      <= pwrite_d;
            prim_data_q   <= prim_data_d;
            sec_data_q    <= sec_data_d;
        end
    end

    assign stall_o        = hold_valid_q;
    assign enable_o       = enable_q;
    assign opcode_o       = opcode_q;
    assign functionType_o = ftype_q;
    assign primOperand_o  = prim_q;
    assign pWrite_o       = pwrite_q;
    assign primData_o     = prim_data_q;
    assign secData_o      = sec_data_q;

endmodule
